vend_change_dispenser: RTL and testbench
========================================

Name: vend_change_dispenser

Overview:
Sequencer between the vending core's change output and a three-tube coin hopper (1, 2 and 5 units).
- Accepts a change amount, breaks it greedily into coin ejections and issues one eject command at a time with a valid/ack handshake.
- Tracks per-denomination tube inventory, credits inserted and refilled coins, and flags exact-change-only and short-change conditions.

Parameters:
CNT_W, 6, width of each tube inventory counter
INIT_CNT, 10, inventory value loaded into every tube at reset
LOW_TH, 2, threshold for exact_change_only
TMO_CYC, 64, hopper ack timeout in cycles (used only with DISP_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  change request present
req_amount  in  4  change to dispense, 0..15 units
req_ready  out  1  block can accept a request
cin_valid  in  1  customer coin accepted by the core
cin_coin  in  2  coin code: C0=00 none, C1=01, C2=10, C5=11
refill_valid  in  1  service refill pulse
refill_coin  in  2  tube to refill, coin code
refill_qty  in  4  coins added
eject_valid  out  1  eject command to hopper
eject_coin  out  2  tube to eject; never C0
eject_ack  in  1  hopper ejected one coin
cmpl  out  1  one-cycle pulse: request fully paid
short_err  out  1  one-cycle pulse: request could not be fully paid
residual  out  4  unpaid amount; valid with cmpl (always 0) or short_err
exact_change_only  out  1  cnt1<LOW_TH or cnt2<LOW_TH
busy  out  1  high in every state except IDLE
cnt1, cnt2, cnt5  out  CNT_W  tube inventories

Behaviour:
Reset (rst=0, asynchronous):
- state IDLE; cnt1/cnt2/cnt5 = INIT_CNT.
- req_ready=1; eject_valid=0; eject_coin=00; cmpl=0; short_err=0; residual=0; busy=0.
- exact_change_only is derived from reset counts.
Registers: rem[3:0] holds the remaining amount.
FSM states: IDLE, SELECT, EJECT, FIN.
- IDLE: req_ready=1. On req_valid, latch rem=req_amount and go to SELECT. req_ready is low in every other state; req_valid outside IDLE is ignored.
- SELECT (one cycle), greedy selection in priority order:
  - rem>=5 and cnt5>0: eject C5
  - rem>=2 and cnt2>0: eject C2
  - rem>=1 and cnt1>0: eject C1
  - rem==0: FIN with success
  - otherwise: FIN with shortage
  - Greedy only, no backtracking: 6 units with cnt1=0 and cnt2>=3 is a shortage, by decision.
- EJECT:
  - eject_valid=1 with eject_coin stable until eject_ack is sampled high.
  - Same cycle as ack: decrement that tube, rem -= coin value, go to SELECT.
  - eject_ack outside EJECT is ignored.
- FIN (one cycle):
  - Success: cmpl=1, residual=0.
  - Shortage: short_err=1, residual=rem.
  - Then IDLE.
- A zero-amount request completes as IDLE -> SELECT -> FIN, so cmpl is high 2 cycles after acceptance.
Latency: one eject per 2 + ack-wait cycles.
Inventory:
- cin_valid with C1/C2/C5 increments the matching tube; C0 is ignored.
- refill adds refill_qty.
- Counters saturate at 2^CNT_W-1 and never go below 0.
- Simultaneous events on one tube in one cycle (coin in, refill, eject decrement) sum to a net delta, then saturate.
- Inventory updates are accepted in every state.
Mid-operation reset: aborts immediately, eject_valid drops and inventory returns to INIT_CNT; no cmpl or short_err is emitted.

Optional Feature:
Macro DISP_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in EJECT and clears on entry.
  - If TMO_CYC cycles pass without eject_ack: go to FIN with short_err=1 and residual=rem (the coin in flight is not decremented).
  - The failing tube is marked faulty (sticky until reset) and treated as empty by SELECT.
  - An extra output hopper_fault[2:0] = {f5,f2,f1} is added.
- Not defined: EJECT waits indefinitely; no hopper_fault port exists.

Decomposition:
Package vend_pkg contains:
- coin codes C0/C1/C2/C5
- coin values 1/2/5
- FSM state encoding
- helper function coin_value(code)
Sub-module vend_tube_counter: one saturating CNT_W counter with inc-by-1, add-qty and dec-by-1 inputs. Instantiated three times.

Test Plan:
1. Reset with defaults, req 8 -> ejects C5, C2, C1 in order; cmpl with residual=0; cnt5=9, cnt2=9, cnt1=9.
2. req 0 -> cmpl exactly 2 cycles after acceptance; no eject_valid.
3. Preload cnt1=0, cnt2=0 (eject to empty), cnt5=1, then req 7 -> one C5 eject, then short_err with residual=2.
4. Hold eject_ack low 5 cycles -> eject_valid and eject_coin stable throughout. Inject cin_valid C5 and refill C5 qty 3 during EJECT -> cnt5 nets correctly on the ack cycle. req_valid asserted while busy -> ignored.
5. Drop cnt1 to 1 (below LOW_TH=2) -> exact_change_only=1. Refill C1 qty 4 -> flag clears next cycle. Refill to saturation -> count stays at 63.
6. Reset asserted during EJECT -> outputs at reset values asynchronously, counts return to 10. With DISP_TIMEOUT_EN: no ack for 64 cycles -> short_err, hopper_fault bit set; next request skips that tube.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared coin codes, coin values and FSM encoding for the change dispenser
package vend_pkg;
   localparam logic [1:0] C0 = 2'b00;
   localparam logic [1:0] C1 = 2'b01;
   localparam logic [1:0] C2 = 2'b10;
   localparam logic [1:0] C5 = 2'b11;
   localparam logic [3:0] V1 = 4'd1;
   localparam logic [3:0] V2 = 4'd2;
   localparam logic [3:0] V5 = 4'd5;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_SELECT = 2'd1;
   localparam logic [1:0] S_EJECT  = 2'd2;
   localparam logic [1:0] S_FIN    = 2'd3;
   function automatic logic [3:0] coin_value(input logic [1:0] code);
      return code == C5 ? V5 : code == C2 ? V2 : code == C1 ? V1 : 4'd0;
   endfunction
endpackage

// File: rtl/vend_change_dispenser_if.sv
// vend_change_dispenser_if: request, hopper eject and completion handshake bundle
//   slave  : dispenser side (takes requests, drives ejects and completion)
//   master : vending core / hopper side
interface vend_change_dispenser_if;
   logic       req_valid;
   logic [3:0] req_amount;
   logic       req_ready;
   logic       eject_valid;
   logic [1:0] eject_coin;
   logic       eject_ack;
   logic       cmpl;
   logic       short_err;
   logic [3:0] residual;
   modport slave (
      input  req_valid, req_amount, eject_ack,
      output req_ready, eject_valid, eject_coin, cmpl, short_err, residual
   );
   modport master (
      output req_valid, req_amount, eject_ack,
      input  req_ready, eject_valid, eject_coin, cmpl, short_err, residual
   );
endinterface

// File: rtl/vend_tube_counter.sv
// vend_tube_counter: saturating coin tube inventory counter
//   clk, rst (async, active-low) ; inc_i : +1 ; qty_i : +qty ; dec_i : -1 ; cnt_o : inventory
//   All same-cycle events are summed to one net delta, then clamped to [0, 2^CNT_W-1].
module vend_tube_counter #(
   parameter int CNT_W    = 6,
   parameter int INIT_CNT = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   input  logic [3:0]       qty_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o
);
   // wide enough that max count + 15 + 1 never wraps
   localparam int W = CNT_W + 5;
   localparam logic [W-1:0] MAX = W'({CNT_W{1'b1}});
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     up, net;
   always_comb begin
      up    = W'(cnt_q) + W'(qty_i) + W'(inc_i);
      net   = up - W'(dec_i && up != '0);
      cnt_d = net > MAX ? MAX[CNT_W-1:0] : net[CNT_W-1:0];
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= CNT_W'(INIT_CNT);
      else      cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: greedy change sequencer for a 1/2/5 coin hopper with tube inventory
//   clk, rst (async, active-low)
//   bus          : request, eject valid/ack and completion (cmpl/short_err/residual)
//   cin_*        : customer coin credited to its tube ; refill_* : service refill
//   exact_change_only, busy, cnt1/cnt2/cnt5 : status and inventories
//   DISP_TIMEOUT_EN : adds hopper ack timeout and hopper_fault[2:0] = {f5,f2,f1}
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int CNT_W    = 6,
   parameter int INIT_CNT = 10,
   parameter int LOW_TH   = 2
`ifdef DISP_TIMEOUT_EN
   ,
   parameter int TMO_CYC  = 64
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   vend_change_dispenser_if.slave bus,
   input  logic                  cin_valid,
   input  logic [1:0]            cin_coin,
   input  logic                  refill_valid,
   input  logic [1:0]            refill_coin,
   input  logic [3:0]            refill_qty,
   output logic                  exact_change_only,
   output logic                  busy,
   output logic [CNT_W-1:0]      cnt1,
   output logic [CNT_W-1:0]      cnt2,
   output logic [CNT_W-1:0]      cnt5
`ifdef DISP_TIMEOUT_EN
   ,
   output logic [2:0]            hopper_fault
`endif
);
   logic [1:0] state_q, state_d, coin_q, coin_d;
   logic [3:0] rem_q, rem_d;
   logic       ok_q, ok_d;
   logic       ack, tmo;
   logic [2:0] fault, avail;
   assign ack   = state_q == S_EJECT && bus.eject_ack;
   // a faulty tube looks empty to the selector
   assign avail = {cnt5 != '0 && !fault[2], cnt2 != '0 && !fault[1], cnt1 != '0 && !fault[0]};
`ifdef DISP_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_q;
   logic [2:0]    fault_q;
   // ack on the last allowed cycle still wins over the timeout
   assign tmo = state_q == S_EJECT && !bus.eject_ack && tmo_q == TW'(TMO_CYC - 1);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         tmo_q   <= '0;
         fault_q <= '0;
      end else begin
         tmo_q   <= state_q == S_EJECT ? tmo_q + TW'(1) : '0;
         fault_q <= fault_q | ({3{tmo}} & {coin_q == C5, coin_q == C2, coin_q == C1});
      end
   assign fault        = fault_q;
   assign hopper_fault = fault_q;
`else
   assign tmo   = 1'b0;
   assign fault = '0;
`endif
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      coin_d  = coin_q;
      ok_d    = ok_q;
      case (state_q)
         S_IDLE:
            if (bus.req_valid) begin
               state_d = S_SELECT;
               rem_d   = bus.req_amount;
            end
         S_SELECT: begin
            coin_d  = rem_q >= V5 && avail[2] ? C5 :
                      rem_q >= V2 && avail[1] ? C2 :
                      rem_q >= V1 && avail[0] ? C1 : C0;
            state_d = coin_d == C0 ? S_FIN : S_EJECT;
            ok_d    = rem_q == 4'd0;
         end
         S_EJECT:
            if (bus.eject_ack) begin
               state_d = S_SELECT;
               rem_d   = rem_q - coin_value(coin_q);
            end else if (tmo) begin
               state_d = S_FIN;
               ok_d    = 1'b0;
            end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         coin_q  <= C0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         coin_q  <= coin_d;
         ok_q    <= ok_d;
      end
   vend_tube_counter #(.CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_tube1 (
      .clk(clk), .rst(rst),
      .inc_i(cin_valid && cin_coin == C1),
      .qty_i(refill_valid && refill_coin == C1 ? refill_qty : 4'd0),
      .dec_i(ack && coin_q == C1),
      .cnt_o(cnt1)
   );
   vend_tube_counter #(.CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_tube2 (
      .clk(clk), .rst(rst),
      .inc_i(cin_valid && cin_coin == C2),
      .qty_i(refill_valid && refill_coin == C2 ? refill_qty : 4'd0),
      .dec_i(ack && coin_q == C2),
      .cnt_o(cnt2)
   );
   vend_tube_counter #(.CNT_W(CNT_W), .INIT_CNT(INIT_CNT)) u_tube5 (
      .clk(clk), .rst(rst),
      .inc_i(cin_valid && cin_coin == C5),
      .qty_i(refill_valid && refill_coin == C5 ? refill_qty : 4'd0),
      .dec_i(ack && coin_q == C5),
      .cnt_o(cnt5)
   );
   assign bus.req_ready   = state_q == S_IDLE;
   assign busy            = state_q != S_IDLE;
   assign bus.eject_valid = state_q == S_EJECT;
   assign bus.eject_coin  = state_q == S_EJECT ? coin_q : C0;
   assign bus.cmpl        = state_q == S_FIN && ok_q;
   assign bus.short_err   = state_q == S_FIN && !ok_q;
   assign bus.residual    = state_q == S_FIN && !ok_q ? rem_q : 4'd0;
   assign exact_change_only = int'(cnt1) < LOW_TH || int'(cnt2) < LOW_TH;
endmodule

// File: tb/tb_vend_change_dispenser.sv
// tb_vend_change_dispenser: scoreboard bench with a greedy reference model and a hopper responder
`timescale 1ns/1ps
module tb_vend_change_dispenser;
   import vend_pkg::*;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cin_valid = 1'b0;
   logic [1:0] cin_coin = 2'b00;
   logic       refill_valid = 1'b0;
   logic [1:0] refill_coin = 2'b00;
   logic [3:0] refill_qty = 4'd0;
   logic       exact_change_only, busy;
   logic [5:0] cnt1, cnt2, cnt5;
`ifdef DISP_TIMEOUT_EN
   logic [2:0] hopper_fault;
`endif
   vend_change_dispenser_if bus();
   vend_change_dispenser dut (
      .clk(clk), .rst(rst), .bus(bus),
      .cin_valid(cin_valid), .cin_coin(cin_coin),
      .refill_valid(refill_valid), .refill_coin(refill_coin), .refill_qty(refill_qty),
      .exact_change_only(exact_change_only), .busy(busy),
      .cnt1(cnt1), .cnt2(cnt2), .cnt5(cnt5)
`ifdef DISP_TIMEOUT_EN
      , .hopper_fault(hopper_fault)
`endif
   );
   always #5 clk = ~clk;
   typedef struct { bit ok; int res; bit zl; int acc; } done_t;
   logic [1:0] coin_q[$];
   done_t      done_q[$];
   int         inv[3] = '{10, 10, 10};
   bit         flt[3] = '{0, 0, 0};
   int         tests = 0, fails = 0, cyc = 0, hold_n = -1;
   logic [1:0] ack_coin = 2'b00;
   function automatic logic [1:0] code(int t);
      return t == 0 ? C1 : t == 1 ? C2 : C5;
   endfunction
   function automatic int val(int t);
      return t == 0 ? 1 : t == 1 ? 2 : 5;
   endfunction
   task automatic chk(string nm, int got, int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask
   task automatic finish_tb();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   // inventory model: plain integer bookkeeping of what the bench itself drove
   always @(posedge clk or negedge rst) begin
      if (!rst) inv <= '{10, 10, 10};
      else for (int t = 0; t < 3; t++) begin
         int n;
         n = inv[t] + ((cin_valid && cin_coin == code(t)) ? 1 : 0)
                    + ((refill_valid && refill_coin == code(t)) ? int'(refill_qty) : 0)
                    - ((bus.eject_ack && ack_coin == code(t)) ? 1 : 0);
         inv[t] <= n < 0 ? 0 : n > 63 ? 63 : n;
      end
   end
   task automatic check_state(string tag);
      chk({tag, "_cnt1"}, cnt1, inv[0]);
      chk({tag, "_cnt2"}, cnt2, inv[1]);
      chk({tag, "_cnt5"}, cnt5, inv[2]);
      chk({tag, "_exact"}, exact_change_only, (inv[0] < 2 || inv[1] < 2) ? 1 : 0);
   endtask
   // greedy plan: largest coin not above the remainder that is stocked and healthy
   task automatic start_req(int amt);
      int rem, pick;
      int c[3];
      rem = amt;
      c = inv;
      forever begin
         pick = -1;
         for (int t = 2; t >= 0; t--)
            if (pick < 0 && val(t) <= rem && c[t] > 0 && !flt[t]) pick = t;
         if (pick < 0) break;
         coin_q.push_back(code(pick));
         c[pick]--;
         rem -= val(pick);
      end
      done_q.push_back('{rem == 0, rem, amt == 0, cyc});
      bus.req_valid  = 1'b1;
      bus.req_amount = 4'(amt);
      @(negedge clk); #1;
      bus.req_valid = 1'b0;
   endtask
   task automatic wait_done(int mode, bit safe);
      bit inj = 0;
      for (int i = 0; i < 500; i++) begin
         cin_valid = 0; refill_valid = 0; bus.req_valid = 0;
         if (done_q.size() == 0 && !busy) return;
         if (mode == 1) begin
            if (safe && $urandom_range(0, 3) == 0) begin
               cin_valid = 1; cin_coin = 2'($urandom_range(0, 3));
            end
            if (safe && $urandom_range(0, 3) == 0) begin
               refill_valid = 1; refill_coin = 2'($urandom_range(1, 3)); refill_qty = 4'($urandom_range(0, 15));
            end
            if (busy && $urandom_range(0, 4) == 0) begin
               bus.req_valid = 1; bus.req_amount = 4'($urandom_range(0, 15));
               chk("busy_ready", bus.req_ready, 0);
            end
         end else if (mode == 2 && bus.eject_ack && !inj) begin
            inj = 1;
            cin_valid = 1; cin_coin = C5;
            refill_valid = 1; refill_coin = C5; refill_qty = 4'd3;
            bus.req_valid = 1; bus.req_amount = 4'd9;
            chk("busy_ready", bus.req_ready, 0);
         end
         @(negedge clk); #1;
      end
      tests++; fails++;
      $display("FAIL wait_done: request still pending after 500 cycles");
      finish_tb();
   endtask
   task automatic run_req(int amt, int mode);
      bit safe;
      safe = inv[0] >= 8 && inv[1] >= 8 && inv[2] >= 8;
      start_req(amt);
      wait_done(mode, safe);
   endtask
   task automatic refill(logic [1:0] c, int q);
      refill_valid = 1; refill_coin = c; refill_qty = 4'(q);
      @(negedge clk); #1;
      refill_valid = 0;
   endtask
   // hopper responder and completion monitor
   initial begin
      bit active;
      int wn;
      logic [1:0] exp;
      done_t d;
      active = 0; wn = 0; exp = C0;
      bus.eject_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            active = 0;
            bus.eject_ack = 1'b0;
         end else begin
            if (bus.eject_ack) begin
               bus.eject_ack = 1'b0;
               active = 0;
            end else if (active && !bus.eject_valid) active = 0;
            if (bus.eject_valid) begin
               if (!active) begin
                  if (coin_q.size() == 0) begin
                     tests++; fails++;
                     $display("FAIL eject_unexpected: got coin %0d expected no eject", bus.eject_coin);
                  end else begin
                     exp = coin_q.pop_front();
                     chk("eject_coin", bus.eject_coin, exp);
                     active = 1;
                     wn = hold_n >= 0 ? hold_n : $urandom_range(0, 3);
                  end
               end else chk("eject_stable", bus.eject_coin, exp);
               if (active) begin
                  if (wn == 0) begin
                     bus.eject_ack = 1'b1;
                     ack_coin = exp;
                  end else wn--;
               end
            end
            if (bus.cmpl || bus.short_err) begin
               chk("cmpl_and_short", bus.cmpl && bus.short_err, 0);
               if (done_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL done_unexpected: got cmpl=%0d short_err=%0d expected none", bus.cmpl, bus.short_err);
               end else begin
                  d = done_q.pop_front();
                  chk("done_ok", bus.cmpl, d.ok);
                  chk("residual", bus.residual, d.res);
                  chk("coins_left", coin_q.size(), 0);
                  if (d.zl) chk("zero_latency", cyc - d.acc, 2);
               end
            end
         end
      end
   end
   initial begin
      bus.req_valid = 1'b0;
      bus.req_amount = 4'd0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_eject_valid", bus.eject_valid, 0);
      chk("rst_eject_coin", bus.eject_coin, 0);
      chk("rst_cmpl", bus.cmpl, 0);
      chk("rst_short", bus.short_err, 0);
      chk("rst_residual", bus.residual, 0);
      chk("rst_busy", busy, 0);
      check_state("rst");
      #1 rst = 1'b1;
      @(negedge clk); #1;
      // greedy split of 8 into 5+2+1
      run_req(8, 0);
      chk("t1_cnt5", cnt5, 9);
      chk("t1_cnt2", cnt2, 9);
      chk("t1_cnt1", cnt1, 9);
      check_state("t1");
      run_req(0, 0);
      // drain C2 and C1, leave one C5, then a shortage
      repeat (9) run_req(2, 0);
      repeat (9) run_req(1, 0);
      repeat (8) run_req(5, 0);
      check_state("t3a");
      run_req(7, 0);
      check_state("t3b");
      chk("t3_exact", exact_change_only, 1);
      refill(C2, 10);
      refill(C1, 1);
      chk("t5_cnt1", cnt1, 1);
      chk("t5_exact_set", exact_change_only, 1);
      refill(C1, 4);
      chk("t5_exact_clr", exact_change_only, 0);
      repeat (5) refill(C1, 15);
      chk("t5_sat", cnt1, 63);
      check_state("t5");
      // ack held off 5 cycles; coin in and refill land on the ack cycle
      hold_n = 5;
      run_req(5, 2);
      hold_n = -1;
      check_state("t4");
`ifdef DISP_TIMEOUT_EN
      begin
         done_t d;
         hold_n = 1000;
         coin_q.push_back(C5);
         d = '{1'b0, 5, 1'b0, cyc};
         done_q.push_back(d);
         bus.req_valid = 1'b1; bus.req_amount = 4'd5;
         @(negedge clk); #1;
         bus.req_valid = 1'b0;
         wait_done(0, 0);
         hold_n = -1;
         flt[2] = 1;
         chk("hopper_fault", hopper_fault, 4);
         run_req(5, 0);
         check_state("tmo");
      end
`endif
      // reset in the middle of an eject
      hold_n = 50;
      start_req(9);
      for (int i = 0; i < 20 && !bus.eject_valid; i++) begin
         @(negedge clk); #1;
      end
      chk("t6_in_eject", bus.eject_valid, 1);
      #2 rst = 1'b0;
      #1;
      chk("t6_eject_valid", bus.eject_valid, 0);
      chk("t6_ready", bus.req_ready, 1);
      chk("t6_busy", busy, 0);
      chk("t6_cnt1", cnt1, 10);
      chk("t6_cnt2", cnt2, 10);
      chk("t6_cnt5", cnt5, 10);
      coin_q.delete();
      done_q.delete();
      hold_n = -1;
      flt = '{0, 0, 0};
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;
      check_state("t6");
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) refill(code($urandom_range(0, 2)), $urandom_range(0, 15));
         run_req($urandom_range(0, 15), 1);
         check_state("rnd");
      end
      chk("queues_empty", coin_q.size() + done_q.size(), 0);
      finish_tb();
   end
endmodule
